// File: rtl/orde_idx_alloc_pkg.sv
// Shared ordering-engine definitions: default block geometry and block FSM states.
package aimc_lib;

    localparam int unsigned ORDE_NUM_PER_BLOCK = 32;
    localparam int unsigned ORDE_NUM_MAX_RD    = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } orde_blk_state_e;

endpackage

// File: rtl/orde_idx_alloc_ring_ptr.sv
// Mod-N ring pointer with increment enable and +1 look-ahead.
//   clk, rst    : clock, asynchronous active-low reset
//   inc         : advance the pointer this cycle
//   ptr         : current pointer value
//   ptr_nxt     : ptr + 1 mod N (combinational)
module orde_ring_ptr #(
    parameter int unsigned N = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] ptr_nxt
);

    localparam int unsigned W = $clog2(N);

    // N is a power of two, so the natural W-bit wrap gives mod-N behaviour
    assign ptr_nxt = ptr + W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/orde_idx_alloc.sv
// Entry-index allocator and in-order retirement controller for one ordering block.
// Hands out write slots for outgoing DMA reads, marks slots done on search
// matches, and retires done slots strictly in issue order.
//   clk, rst                         : clock, asynchronous active-low reset
//   alloc_req / alloc_ready          : packet insertion handshake
//   empty_idx(_valid)                : slot the next accepted packet goes to
//   resp_valid / resp_idx            : search match, global index
//   oldest_idx(_valid)               : head slot
//   oldest_idx_next(_valid)          : head+1 slot
//   retire_ready                     : downstream accepts a retirement
//   pop_idx(_valid)                  : registered retirement pulse
//   drain_req / drain_done           : stop allocating and empty the block
//   count                            : outstanding slots
//   err                              : sticky protocol error
module orde_idx_alloc
    import aimc_lib::*;
#(
    parameter int unsigned NUM_PER_BLOCK = ORDE_NUM_PER_BLOCK,
    parameter int unsigned NUM_MAX_RD    = ORDE_NUM_MAX_RD,
    parameter int unsigned BLOCK_IDX     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alloc_req,
    output logic                             alloc_ready,
    output logic [$clog2(NUM_PER_BLOCK)-1:0] empty_idx,
    output logic                             empty_idx_valid,
    input  logic                             resp_valid,
    input  logic [$clog2(NUM_MAX_RD)-1:0]    resp_idx,
    output logic [$clog2(NUM_PER_BLOCK)-1:0] oldest_idx,
    output logic                             oldest_idx_valid,
    output logic [$clog2(NUM_PER_BLOCK)-1:0] oldest_idx_next,
    output logic                             oldest_idx_next_valid,
    input  logic                             retire_ready,
    output logic [$clog2(NUM_PER_BLOCK)-1:0] pop_idx,
    output logic                             pop_idx_valid,
    input  logic                             drain_req,
    output logic                             drain_done,
    output logic [$clog2(NUM_PER_BLOCK):0]   count,
    output logic                             err
);

    localparam int unsigned LW = $clog2(NUM_PER_BLOCK);
    localparam int unsigned RW = $clog2(NUM_MAX_RD);
    localparam int unsigned CW = LW + 1;
    localparam int unsigned HW = RW - LW;

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_RUN   = 2'(RUN);
    localparam logic [1:0] ST_DRAIN = 2'(DRAIN);

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [LW-1:0]            hd;
    logic [LW-1:0]            hd_nxt;
    logic [LW-1:0]            tl;
    logic [LW-1:0]            tl_nxt;
    logic [NUM_PER_BLOCK-1:0] vld;
    logic [NUM_PER_BLOCK-1:0] done;
    logic [NUM_PER_BLOCK-1:0] vld_nxt;
    logic [NUM_PER_BLOCK-1:0] done_nxt;
    logic [CW-1:0]            count_nxt;

    logic          full;
    logic          in_drain;
    logic          alloc_fire;
    logic          alloc_drop_err;
    logic          resp_hit;
    logic [LW-1:0] resp_local;
    logic          resp_ok;
    logic          resp_err;
    logic          retire_fire;
    logic          unused_tl_nxt;

    orde_ring_ptr #(.N(NUM_PER_BLOCK)) u_head (
        .clk     (clk),
        .rst     (rst),
        .inc     (retire_fire),
        .ptr     (hd),
        .ptr_nxt (hd_nxt)
    );

    orde_ring_ptr #(.N(NUM_PER_BLOCK)) u_tail (
        .clk     (clk),
        .rst     (rst),
        .inc     (alloc_fire),
        .ptr     (tl),
        .ptr_nxt (tl_nxt)
    );

    // tail look-ahead has no consumer in this block
    assign unused_tl_nxt = ^tl_nxt;

    // Allocation: blocked when full or draining; only a full-ring drop is an error
    assign full           = (count == CW'(NUM_PER_BLOCK));
    assign in_drain       = (state == ST_DRAIN);
    assign alloc_ready    = !full && !in_drain;
    assign alloc_fire     = alloc_req && alloc_ready;
    assign alloc_drop_err = alloc_req && full && !in_drain;

    // Block base is a multiple of N, so the upper index bits select the block
    assign resp_hit   = (resp_idx[RW-1:LW] == HW'(BLOCK_IDX));
    assign resp_local = resp_idx[LW-1:0];
    assign resp_ok    = resp_valid && resp_hit && vld[resp_local] && !done[resp_local];
    assign resp_err   = resp_valid && !(resp_hit && vld[resp_local] && !done[resp_local]);

    assign retire_fire = vld[hd] && done[hd] && retire_ready;

    assign count_nxt = count + CW'(alloc_fire) - CW'(retire_fire);

    // Per-slot status update; retire, allocate and mark never hit the same bit
    always_comb begin
        vld_nxt  = vld;
        done_nxt = done;
        if (retire_fire) begin
            vld_nxt[hd]  = 1'b0;
            done_nxt[hd] = 1'b0;
        end
        if (alloc_fire) begin
            vld_nxt[tl] = 1'b1;
        end
        if (resp_ok) begin
            done_nxt[resp_local] = 1'b1;
        end
    end

    // Block FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (drain_req) begin
                    state_nxt = ST_DRAIN;
                end else if (alloc_fire) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (drain_req) begin
                    state_nxt = ST_DRAIN;
                end else if (count_nxt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!drain_req && (count == '0)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            count         <= '0;
            vld           <= '0;
            done          <= '0;
            pop_idx       <= '0;
            pop_idx_valid <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            vld           <= vld_nxt;
            done          <= done_nxt;
            pop_idx_valid <= retire_fire;
            if (retire_fire) begin
                pop_idx <= hd;
            end
            err <= err | alloc_drop_err | resp_err;
        end
    end

    assign empty_idx             = tl;
    assign empty_idx_valid       = alloc_ready;
    assign oldest_idx            = hd;
    assign oldest_idx_valid      = (count != '0);
    assign oldest_idx_next       = hd_nxt;
    assign oldest_idx_next_valid = (count > CW'(1));
    assign drain_done            = in_drain && (count == '0);

endmodule

// File: tb/tb_orde_idx_alloc.sv
// Self-checking bench for orde_idx_alloc (N=32, BLOCK_IDX=1).
module tb_orde_idx_alloc;

    localparam int N    = 32;
    localparam int BLK  = 1;
    localparam int BASE = N * BLK;

    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       alloc_ready;
    logic [4:0] empty_idx;
    logic       empty_idx_valid;
    logic       resp_valid;
    logic [8:0] resp_idx;
    logic [4:0] oldest_idx;
    logic       oldest_idx_valid;
    logic [4:0] oldest_idx_next;
    logic       oldest_idx_next_valid;
    logic       retire_ready;
    logic [4:0] pop_idx;
    logic       pop_idx_valid;
    logic       drain_req;
    logic       drain_done;
    logic [5:0] count;
    logic       err;

    int errors = 0;
    int checks = 0;

    orde_idx_alloc #(.NUM_PER_BLOCK(32), .NUM_MAX_RD(512), .BLOCK_IDX(1)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .alloc_req             (alloc_req),
        .alloc_ready           (alloc_ready),
        .empty_idx             (empty_idx),
        .empty_idx_valid       (empty_idx_valid),
        .resp_valid            (resp_valid),
        .resp_idx              (resp_idx),
        .oldest_idx            (oldest_idx),
        .oldest_idx_valid      (oldest_idx_valid),
        .oldest_idx_next       (oldest_idx_next),
        .oldest_idx_next_valid (oldest_idx_next_valid),
        .retire_ready          (retire_ready),
        .pop_idx               (pop_idx),
        .pop_idx_valid         (pop_idx_valid),
        .drain_req             (drain_req),
        .drain_done            (drain_done),
        .count                 (count),
        .err                   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: issue-ordered queue of outstanding slots
    int q[$];
    bit m_vld[N];
    bit m_done[N];
    int m_hd, m_tl, m_st;   // m_st: 0 idle, 1 run, 2 drain
    bit m_pop_v, m_err;
    int m_pop_i;

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < N; i++) begin
            m_vld[i] = 0;
            m_done[i] = 0;
        end
        m_hd = 0; m_tl = 0; m_st = 0;
        m_pop_v = 0; m_pop_i = 0; m_err = 0;
    endfunction

    function automatic void model_step(input bit a, input bit rv, input int ridx,
                                       input bit rr, input bit dr);
        int sz  = q.size();
        bit ar  = (sz < N) && (m_st != 2);
        bit acc = a && ar;
        bit ret = (sz > 0) && m_done[q[0]] && rr;
        bit set_done = 0;
        int loc = 0;
        if (a && !ar && m_st != 2) m_err = 1;
        if (rv) begin
            if (ridx < BASE || ridx >= BASE + N) m_err = 1;
            else begin
                loc = ridx - BASE;
                if (m_vld[loc] && !m_done[loc]) set_done = 1;
                else m_err = 1;
            end
        end
        m_pop_v = ret;
        if (ret) begin
            m_pop_i = q.pop_front();
            m_vld[m_pop_i] = 0;
            m_done[m_pop_i] = 0;
            m_hd = (m_hd + 1) % N;
        end
        if (acc) begin
            q.push_back(m_tl);
            m_vld[m_tl] = 1;
            m_tl = (m_tl + 1) % N;
        end
        if (set_done) m_done[loc] = 1;
        case (m_st)
            0: if (dr) m_st = 2; else if (acc) m_st = 1;
            1: if (dr) m_st = 2; else if (q.size() == 0) m_st = 0;
            default: if (!dr && sz == 0) m_st = 0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) model_step(alloc_req, resp_valid, int'(resp_idx), retire_ready, drain_req);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        alloc_req = 0; resp_valid = 0; resp_idx = '0; retire_ready = 0; drain_req = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (alloc_ready !== 1'b1 || empty_idx_valid !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b/%b exp=1/1", alloc_ready, empty_idx_valid); end
        checks++; if (empty_idx !== 5'd0) begin errors++; $display("FAIL reset_empty_idx got=%0d exp=0", empty_idx); end
        checks++; if (oldest_idx !== 5'd0 || oldest_idx_valid !== 1'b0) begin errors++; $display("FAIL reset_oldest got=%0d/%b exp=0/0", oldest_idx, oldest_idx_valid); end
        checks++; if (oldest_idx_next !== 5'd1 || oldest_idx_next_valid !== 1'b0) begin errors++; $display("FAIL reset_oldest_next got=%0d/%b exp=1/0", oldest_idx_next, oldest_idx_next_valid); end
        checks++; if (pop_idx_valid !== 1'b0 || pop_idx !== 5'd0) begin errors++; $display("FAIL reset_pop got=%0d/%b exp=0/0", pop_idx, pop_idx_valid); end
        checks++; if (err !== 1'b0 || drain_done !== 1'b0) begin errors++; $display("FAIL reset_err_drain got=%b/%b exp=0/0", err, drain_done); end
    endtask

    task automatic test_alloc3();
        for (int i = 0; i < 3; i++) begin
            checks++; if (empty_idx !== 5'(i)) begin errors++; $display("FAIL alloc_empty_idx got=%0d exp=%0d", empty_idx, i); end
            alloc_req = 1;
            step();
        end
        alloc_req = 0;
        checks++; if (count !== 6'd3) begin errors++; $display("FAIL alloc_count got=%0d exp=3", count); end
        checks++; if (oldest_idx !== 5'd0 || oldest_idx_valid !== 1'b1) begin errors++; $display("FAIL alloc_oldest got=%0d/%b exp=0/1", oldest_idx, oldest_idx_valid); end
        checks++; if (oldest_idx_next !== 5'd1 || oldest_idx_next_valid !== 1'b1) begin errors++; $display("FAIL alloc_oldest_next got=%0d/%b exp=1/1", oldest_idx_next, oldest_idx_next_valid); end
    endtask

    task automatic test_retire_order();
        retire_ready = 1;
        resp_valid = 1; resp_idx = 9'd34;
        step();
        checks++; if (pop_idx_valid !== 1'b0) begin errors++; $display("FAIL order_no_pop_34 got=%b exp=0", pop_idx_valid); end
        resp_idx = 9'd32;
        step();
        checks++; if (pop_idx_valid !== 1'b0) begin errors++; $display("FAIL order_no_pop_early got=%b exp=0", pop_idx_valid); end
        resp_idx = 9'd33;
        step();
        resp_valid = 0;
        for (int k = 0; k < 3; k++) begin
            checks++; if (pop_idx_valid !== 1'b1 || pop_idx !== 5'(k)) begin errors++; $display("FAIL order_pop got=%0d/%b exp=%0d/1", pop_idx, pop_idx_valid, k); end
            step();
        end
        checks++; if (pop_idx_valid !== 1'b0 || count !== 6'd0) begin errors++; $display("FAIL order_end got=%b/%0d exp=0/0", pop_idx_valid, count); end
        checks++; if (alloc_ready !== 1'b1 || oldest_idx_valid !== 1'b0 || drain_done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL order_idle got=%b%b%b%b exp=1000", alloc_ready, oldest_idx_valid, drain_done, err); end
        retire_ready = 0;
    endtask

    task automatic test_full_wrap();
        int bad = 0;
        do_reset();
        for (int i = 0; i < N; i++) begin
            if (empty_idx !== 5'(i)) bad++;
            alloc_req = 1;
            step();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL fill_seq got=%0d wrong exp=0", bad); end
        checks++; if (alloc_ready !== 1'b0 || count !== 6'd32 || err !== 1'b0) begin errors++; $display("FAIL full_state got=%b/%0d/%b exp=0/32/0", alloc_ready, count, err); end
        step();   // 33rd request is dropped
        alloc_req = 0;
        checks++; if (err !== 1'b1 || count !== 6'd32) begin errors++; $display("FAIL overflow_err got=%b/%0d exp=1/32", err, count); end
        retire_ready = 1; resp_valid = 1; resp_idx = 9'd32;
        step();
        resp_valid = 0;
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_retire_cycle got=%b exp=0", alloc_ready); end
        step();
        checks++; if (pop_idx_valid !== 1'b1 || pop_idx !== 5'd0) begin errors++; $display("FAIL full_pop got=%0d/%b exp=0/1", pop_idx, pop_idx_valid); end
        checks++; if (alloc_ready !== 1'b1 || empty_idx !== 5'd0 || count !== 6'd31) begin errors++; $display("FAIL full_reopen got=%b/%0d/%0d exp=1/0/31", alloc_ready, empty_idx, count); end
    endtask

    task automatic test_wrap_next();
        for (int s = 1; s <= 30; s++) begin
            resp_valid = 1; resp_idx = 9'(BASE + s);
            step();
        end
        resp_valid = 0;
        step(); step();
        alloc_req = 1;
        step();
        alloc_req = 0;
        checks++; if (oldest_idx !== 5'd31 || oldest_idx_next !== 5'd0 || oldest_idx_next_valid !== 1'b1 || count !== 6'd2) begin errors++; $display("FAIL wrap_oldest got=%0d/%0d/%b/%0d exp=31/0/1/2", oldest_idx, oldest_idx_next, oldest_idx_next_valid, count); end
        retire_ready = 0; resp_valid = 1; resp_idx = 9'd63;
        step();
        resp_valid = 0;
        for (int k = 0; k < 5; k++) begin
            checks++; if (pop_idx_valid !== 1'b0) begin errors++; $display("FAIL backpressure_pop cycle=%0d got=%b exp=0", k, pop_idx_valid); end
            step();
        end
        retire_ready = 1;
        step();
        checks++; if (pop_idx_valid !== 1'b1 || pop_idx !== 5'd31) begin errors++; $display("FAIL wrap_pop got=%0d/%b exp=31/1", pop_idx, pop_idx_valid); end
        step();
        checks++; if (pop_idx_valid !== 1'b0 || count !== 6'd1 || oldest_idx !== 5'd0) begin errors++; $display("FAIL wrap_after got=%b/%0d/%0d exp=0/1/0", pop_idx_valid, count, oldest_idx); end
        retire_ready = 0;
    endtask

    task automatic test_errors();
        int bad_idx[3] = '{10, 64, 33};
        foreach (bad_idx[i]) begin
            do_reset();
            alloc_req = 1; step(); alloc_req = 0;
            resp_valid = 1; resp_idx = 9'(bad_idx[i]);
            step();
            resp_valid = 0;
            checks++; if (err !== 1'b1 || count !== 6'd1) begin errors++; $display("FAIL bad_resp idx=%0d got=%b/%0d exp=1/1", bad_idx[i], err, count); end
        end
        do_reset();
        alloc_req = 1; step(); alloc_req = 0;
        resp_valid = 1; resp_idx = 9'd32;
        step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL first_resp_err got=%b exp=0", err); end
        step();
        resp_valid = 0;
        checks++; if (err !== 1'b1 || count !== 6'd1 || pop_idx_valid !== 1'b0) begin errors++; $display("FAIL dup_resp got=%b/%0d/%b exp=1/1/0", err, count, pop_idx_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        alloc_req = 1; step(); step(); alloc_req = 0;
        retire_ready = 1; resp_valid = 1; resp_idx = 9'd32;
        step();
        resp_valid = 0; alloc_req = 1;
        step();
        alloc_req = 0;
        checks++; if (count !== 6'd2 || pop_idx_valid !== 1'b1 || empty_idx !== 5'd3) begin errors++; $display("FAIL alloc_retire_same got=%0d/%b/%0d exp=2/1/3", count, pop_idx_valid, empty_idx); end
        retire_ready = 0;
    endtask

    task automatic test_drain();
        int pops = 0;
        do_reset();
        alloc_req = 1;
        repeat (4) step();
        alloc_req = 0; drain_req = 1;
        step();
        checks++; if (alloc_ready !== 1'b0 || empty_idx_valid !== 1'b0 || drain_done !== 1'b0) begin errors++; $display("FAIL drain_block got=%b/%b/%b exp=0/0/0", alloc_ready, empty_idx_valid, drain_done); end
        alloc_req = 1;
        step();
        alloc_req = 0;
        checks++; if (count !== 6'd4 || err !== 1'b0) begin errors++; $display("FAIL drain_drop got=%0d/%b exp=4/0", count, err); end
        retire_ready = 1;
        for (int s = 0; s < 4; s++) begin
            resp_valid = 1; resp_idx = 9'(BASE + s);
            step();
            if (pop_idx_valid) pops++;
        end
        resp_valid = 0;
        for (int c = 0; c < 16 && !drain_done; c++) begin
            step();
            if (pop_idx_valid) pops++;
        end
        checks++; if (drain_done !== 1'b1 || pops != 4 || count !== 6'd0) begin errors++; $display("FAIL drain_done got=%b/%0d/%0d exp=1/4/0", drain_done, pops, count); end
        drain_req = 0;
        step();
        checks++; if (alloc_ready !== 1'b1 || drain_done !== 1'b0) begin errors++; $display("FAIL drain_release got=%b/%b exp=1/0", alloc_ready, drain_done); end
        retire_ready = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        alloc_req = 1; repeat (3) step(); alloc_req = 0;
        retire_ready = 1; resp_valid = 1; resp_idx = 9'd32;
        step();
        resp_valid = 0;
        #2;
        rst = 0;
        model_reset();
        #1;
        checks++; if (count !== 6'd0 || pop_idx_valid !== 1'b0 || oldest_idx_valid !== 1'b0 || alloc_ready !== 1'b1) begin errors++; $display("FAIL async_reset got=%0d/%b/%b/%b exp=0/0/0/1", count, pop_idx_valid, oldest_idx_valid, alloc_ready); end
        @(posedge clk); #1;
        rst = 1;
        step();
        checks++; if (pop_idx_valid !== 1'b0 || empty_idx !== 5'd0) begin errors++; $display("FAIL async_after got=%b/%0d exp=0/0", pop_idx_valid, empty_idx); end
        retire_ready = 0;
    endtask

    task automatic test_random();
        logic [32:0] act, exp;
        int cand[$];
        do_reset();
        for (int c = 0; c < 800; c++) begin
            act = {count, alloc_ready, empty_idx_valid, empty_idx, oldest_idx, oldest_idx_valid,
                   oldest_idx_next, oldest_idx_next_valid, pop_idx, pop_idx_valid, err, drain_done};
            exp = {6'(q.size()), ((q.size() < N) && m_st != 2), ((q.size() < N) && m_st != 2),
                   5'(m_tl), 5'(m_hd), (q.size() > 0), 5'((m_hd + 1) % N), (q.size() > 1),
                   5'(m_pop_i), m_pop_v, m_err, (m_st == 2 && q.size() == 0)};
            checks++; if (act !== exp) begin errors++; $display("FAIL random cycle=%0d got=%h exp=%h", c, act, exp); end
            alloc_req = 1'($urandom % 2);
            retire_ready = ($urandom % 4) != 0;
            if ($urandom % 60 == 0) drain_req = !drain_req;
            resp_valid = 0;
            cand.delete();
            foreach (q[i]) if (!m_done[q[i]]) cand.push_back(q[i]);
            if (cand.size() > 0 && ($urandom % 3) != 0) begin
                resp_valid = 1;
                resp_idx = 9'(BASE + cand[$urandom % cand.size()]);
            end
            if ($urandom % 200 == 0) begin
                resp_valid = 1;
                resp_idx = 9'($urandom % 512);
            end
            step();
        end
        alloc_req = 0; resp_valid = 0; drain_req = 0; retire_ready = 0;
    endtask

    initial begin
        rst = 0;
        alloc_req = 0; resp_valid = 0; resp_idx = '0; retire_ready = 0; drain_req = 0;
        test_reset();
        test_alloc3();
        test_retire_order();
        test_full_wrap();
        test_wrap_next();
        test_errors();
        test_back_to_back();
        test_drain();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
